// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths, types and constants for the OtterMCU register file
package reg_file_pkg;
    localparam int XLEN       = 32;
    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       word_t;
    localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_file_rf_read_port.sv
// rf_read_port: combinational register read mux with x0 forced to zero
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int NUM_REGS   = REG_COUNT,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);
    assign data = (addr == ADDR_WIDTH'(REG_ZERO)) ? '0 : regs[addr];
endmodule

// File: rtl/reg_file.sv
// reg_file: 32x32 RISC-V integer register file, two async read ports, one sync write port
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int NUM_REGS   = REG_COUNT,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] r_addr1,
    input  logic [ADDR_WIDTH-1:0] r_addr2,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] r_rs1,
    output logic [DATA_WIDTH-1:0] r_rs2
);
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    always_comb begin
        regs_d = regs_q;
        if (w_en && w_addr != ADDR_WIDTH'(REG_ZERO)) regs_d[w_addr] = w_data;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '{default: '0};
        else     regs_q <= regs_d;
    end
    rf_read_port #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)) u_rd1 (
        .regs(regs_q), .addr(r_addr1), .data(r_rs1)
    );
    rf_read_port #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)) u_rd2 (
        .regs(regs_q), .addr(r_addr2), .data(r_rs2)
    );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file
module tb_reg_file;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  r_addr1 = '0, r_addr2 = '0, w_addr = '0;
    logic        w_en = 1'b0;
    logic [31:0] w_data = '0;
    logic [31:0] r_rs1, r_rs2;
    int vectors = 0;
    int errs = 0;
    reg_file dut (
        .clk(clk), .rst(rst), .r_addr1(r_addr1), .r_addr2(r_addr2),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .r_rs1(r_rs1), .r_rs2(r_rs2)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        w_en = 1'b1; w_addr = a; w_data = d;
        @(posedge clk);
        #1 w_en = 1'b0;
    endtask
    logic [31:0] pats [8] = '{32'h00000000, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555,
                              32'h12345678, 32'h87654321, 32'hF0F0F0F0, 32'h0F0F0F0F};
    initial begin
        #1 r_addr1 = 5'd7;
        #1 chk("in_reset", r_rs1, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            r_addr1 = 5'(i);
            #1 chk($sformatf("reset_sweep x%0d", i), r_rs1, 32'h0);
        end
        wr(5'd1, 32'hDEADBEEF);
        r_addr1 = 5'd1;
        #1 chk("write_x1", r_rs1, 32'hDEADBEEF);
        wr(5'd0, 32'hDEADBEEF);
        r_addr1 = 5'd0;
        #1 chk("x0_guard", r_rs1, 32'h0);
        wr(5'd5, 32'h12345678);
        wr(5'd10, 32'h87654321);
        r_addr1 = 5'd5; r_addr2 = 5'd10;
        #1 chk("dual_rs1", r_rs1, 32'h12345678);
        chk("dual_rs2", r_rs2, 32'h87654321);
        wr(5'd3, 32'hABCDEF00);
        @(negedge clk);
        w_en = 1'b0; w_addr = 5'd3; w_data = 32'h11111111;
        @(posedge clk);
        #1 r_addr1 = 5'd3;
        #1 chk("w_en_low", r_rs1, 32'hABCDEF00);
        wr(5'd31, 32'hFFFFFFFF);
        r_addr2 = 5'd31;
        #1 chk("x31_ones", r_rs2, 32'hFFFFFFFF);
        for (int i = 0; i < 8; i++) wr(5'(20 + i), pats[i]);
        for (int i = 0; i < 8; i++) begin
            r_addr1 = 5'(20 + i);
            #1 chk($sformatf("pattern x%0d", 20 + i), r_rs1, pats[i]);
        end
        wr(5'd15, 32'hCAFEBABE);
        @(negedge clk);
        r_addr1 = 5'd15; w_en = 1'b1; w_addr = 5'd16; w_data = 32'hDEADC0DE;
        #1 chk("rw_diff_before", r_rs1, 32'hCAFEBABE);
        @(posedge clk);
        #1 w_en = 1'b0;
        chk("rw_diff_after", r_rs1, 32'hCAFEBABE);
        r_addr2 = 5'd16;
        #1 chk("rw_diff_x16", r_rs2, 32'hDEADC0DE);
        @(negedge clk);
        r_addr1 = 5'd7; w_en = 1'b1; w_addr = 5'd7; w_data = 32'h77777777;
        #1 chk("rw_same_old", r_rs1, 32'h0);
        @(posedge clk);
        #1 w_en = 1'b0;
        chk("rw_same_new", r_rs1, 32'h77777777);
        wr(5'd7, 32'h0000AAAA);
        wr(5'd7, 32'h0000BBBB);
        #1 chk("b2b_same_last", r_rs1, 32'h0000BBBB);
        for (int i = 1; i < 32; i++) wr(5'(i), 32'h10000000 + i);
        for (int i = 0; i < 32; i++) begin
            r_addr1 = 5'(i); r_addr2 = 5'(31 - i);
            #1 chk($sformatf("sweep rs1 x%0d", i), r_rs1, i == 0 ? 32'h0 : 32'h10000000 + i);
            chk($sformatf("sweep rs2 x%0d", 31 - i), r_rs2, i == 31 ? 32'h0 : 32'h10000000 + 31 - i);
        end
        @(negedge clk);
        r_addr1 = 5'd5; r_addr2 = 5'd9;
        #1 chk("pre_rst_x5", r_rs1, 32'h10000005);
        #1 rst = 1'b1;
        #1 chk("async_rst_rs1", r_rs1, 32'h0);
        chk("async_rst_rs2", r_rs2, 32'h0);
        w_en = 1'b1; w_addr = 5'd9; w_data = 32'h0BADF00D;
        @(posedge clk);
        #1 chk("write_in_rst", r_rs2, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        w_addr = 5'd9; w_data = 32'h99999999;
        @(posedge clk);
        #1 w_en = 1'b0;
        chk("first_write_after_rst", r_rs2, 32'h99999999);
        chk("other_still_clear", r_rs1, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
